// File: rtl/match_sequencer.sv
// match_sequencer: quidditch match flow controller (frame tick, match FSM, scores, recenter).
// Optional feature: define MATCH_PAUSE_EN to add pause_button and the PAUSE state.
module match_sequencer #(
  parameter int TICK_DIV        = 833333,
  parameter int KICKOFF_TICKS   = 120,
  parameter int GOAL_HOLD_TICKS = 90,
  parameter int WIN_SCORE       = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_button,
`ifdef MATCH_PAUSE_EN
  input  logic       pause_button,
`endif
  input  logic       goal_team1,
  input  logic       goal_team2,
  output logic       move_tick,
  output logic       recenter,
  output logic [3:0] team1_score,
  output logic [3:0] team2_score,
  output logic [2:0] game_state,
  output logic [1:0] winner
);
  localparam int DW   = $clog2(TICK_DIV);
  localparam int PMAX = KICKOFF_TICKS > GOAL_HOLD_TICKS ? KICKOFF_TICKS : GOAL_HOLD_TICKS;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KICK  = 3'd1,
    S_PLAY  = 3'd2,
    S_GOAL  = 3'd3,
    S_OVER  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] phase;
  logic [2:0]    start_sync;
  logic          frame_tick, start_press, pause_press;
  logic          goal1, goal2, win1, win2, restart;
  logic          move_d, recenter_d;
  logic [3:0]    score1_d, score2_d;
  logic [1:0]    winner_d;

  assign frame_tick  = div_cnt == DW'(TICK_DIV - 1);
  assign start_press = start_sync[2] & ~start_sync[1];
  assign goal1       = goal_team1 & ~goal_team2;
  assign goal2       = goal_team2 & ~goal_team1;
  assign win1        = team1_score == 4'(WIN_SCORE - 1);
  assign win2        = team2_score == 4'(WIN_SCORE - 1);
  assign restart     = (state == S_IDLE || state == S_OVER) && start_press;
  assign game_state  = state;

  // Free-running frame divider, independent of match state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt <= '0;
    else div_cnt <= frame_tick ? '0 : div_cnt + DW'(1);

  // Two-flop synchronizer plus an edge flop; a press is the falling edge of the synced level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) start_sync <= '1;
    else start_sync <= {start_sync[1:0], start_button};

`ifdef MATCH_PAUSE_EN
  logic [2:0] pause_sync;

  // Pause button gets the same synchronizer and press detection as start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pause_sync <= '1;
    else pause_sync <= {pause_sync[1:0], pause_button};

  assign pause_press = pause_sync[2] & ~pause_sync[1];
`else
  assign pause_press = 1'b0;
`endif

  // Match state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_next;

  // Next-state logic; a lone goal outranks a pause press in the same cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_OVER: state_next = start_press ? S_KICK : state;
      S_KICK:  state_next = frame_tick && phase == PW'(KICKOFF_TICKS - 1) ? S_PLAY : S_KICK;
      S_PLAY:  state_next = goal1 ? (win1 ? S_OVER : S_GOAL) :
                            goal2 ? (win2 ? S_OVER : S_GOAL) :
                            pause_press ? S_PAUSE : S_PLAY;
      S_GOAL:  state_next = frame_tick && phase == PW'(GOAL_HOLD_TICKS - 1) ? S_KICK : S_GOAL;
      S_PAUSE: state_next = pause_press ? S_PLAY : S_PAUSE;
      default: state_next = S_IDLE;
    endcase
  end

  // Phase counter: frame ticks spent in the current timed state, cleared on every transition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase <= '0;
    else phase <= state_next != state ? '0 :
                  frame_tick && (state == S_KICK || state == S_GOAL) ? phase + PW'(1) : phase;

  // Output decode: next values of the registered outputs
  always_comb begin
    move_d     = frame_tick && state == S_PLAY && state_next == S_PLAY;
    recenter_d = state_next == S_KICK && state != S_KICK;
    score1_d   = restart ? 4'd0 : state == S_PLAY && goal1 ? team1_score + 4'd1 : team1_score;
    score2_d   = restart ? 4'd0 : state == S_PLAY && goal2 ? team2_score + 4'd1 : team2_score;
    winner_d   = restart ? 2'd0 :
                 state == S_PLAY && goal1 && win1 ? 2'd1 :
                 state == S_PLAY && goal2 && win2 ? 2'd2 : winner;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      move_tick   <= 1'b0;
      recenter    <= 1'b0;
      team1_score <= '0;
      team2_score <= '0;
      winner      <= '0;
    end else begin
      move_tick   <= move_d;
      recenter    <= recenter_d;
      team1_score <= score1_d;
      team2_score <= score2_d;
      winner      <= winner_d;
    end
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed plus randomized checks of match_sequencer against a behavioural model.
module tb_match_sequencer;
  localparam int TD = 4;
  localparam int KT = 2;
  localparam int GH = 3;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_button = 1'b1;
  logic       pause_button = 1'b1;
  logic       goal_team1 = 1'b0;
  logic       goal_team2 = 1'b0;
  logic       move_tick, recenter;
  logic [3:0] team1_score, team2_score;
  logic [2:0] game_state;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  int rec_cnt = 0;
  int r;
  bit armed = 1'b0;

  match_sequencer #(
    .TICK_DIV(TD), .KICKOFF_TICKS(KT), .GOAL_HOLD_TICKS(GH), .WIN_SCORE(WS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_button(start_button),
`ifdef MATCH_PAUSE_EN
    .pause_button(pause_button),
`endif
    .goal_team1(goal_team1),
    .goal_team2(goal_team2),
    .move_tick(move_tick),
    .recenter(recenter),
    .team1_score(team1_score),
    .team2_score(team2_score),
    .game_state(game_state),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycle count since reset gives the frame tick, button
  // presses come from the raw sample history, and the match rules are applied per edge.
  int m_state = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_ph = 0, m_div = 0, ns;
  bit m_move = 0, m_rec = 0, tick, sp, pp;
  bit [2:0] sh = '1, phh = '1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_ph = 0; m_div = 0;
      m_move = 0; m_rec = 0; sh = '1; phh = '1;
    end else begin
      tick = m_div == TD - 1;
      sp = sh[2] && !sh[1];
      sh = {sh[1:0], start_button};
`ifdef MATCH_PAUSE_EN
      pp = phh[2] && !phh[1];
      phh = {phh[1:0], pause_button};
`else
      pp = 0;
`endif
      ns = m_state;
      m_rec = 0;
      case (m_state)
        0, 4: if (sp) begin
          ns = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_rec = 1; m_ph = 0;
        end
        1: if (tick) begin
          m_ph++;
          if (m_ph == KT) begin ns = 2; m_ph = 0; end
        end
        2: if (goal_team1 != goal_team2) begin
          if (goal_team1) begin
            m_s1++;
            if (m_s1 == WS) begin ns = 4; m_win = 1; end else ns = 3;
          end else begin
            m_s2++;
            if (m_s2 == WS) begin ns = 4; m_win = 2; end else ns = 3;
          end
          m_ph = 0;
        end else if (pp) ns = 5;
        3: if (tick) begin
          m_ph++;
          if (m_ph == GH) begin ns = 1; m_rec = 1; m_ph = 0; end
        end
        5: if (pp) ns = 2;
        default: ns = 0;
      endcase
      m_move = tick && m_state == 2 && ns == 2;
      m_div = (m_div + 1) % TD;
      m_state = ns;
    end
  end

  // Every-cycle comparison of the DUT outputs against the model
  always @(negedge clk) if (armed) begin
    chk("move_tick", move_tick, m_move);
    chk("recenter", recenter, m_rec);
    chk("team1_score", team1_score, m_s1);
    chk("team2_score", team2_score, m_s2);
    chk("game_state", game_state, m_state);
    chk("winner", winner, m_win);
  end

  task automatic cyc();
    @(negedge clk);
    mv_cnt += move_tick;
    rec_cnt += recenter;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (game_state != s && n < budget) begin
      cyc();
      n++;
    end
    chk(name, game_state, s);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    #1 rst_n = 1'b1;
  endtask

  task automatic start_game();
    start_button = 1'b0;
    repeat (4) cyc();
    start_button = 1'b1;
    wait_state(1, 10, "start_kick");
    wait_state(2, 20, "start_play");
  endtask

  task automatic check_zero(input string name);
    chk({name, "_move"}, move_tick, 0);
    chk({name, "_rec"}, recenter, 0);
    chk({name, "_s1"}, team1_score, 0);
    chk({name, "_s2"}, team2_score, 0);
    chk({name, "_state"}, game_state, 0);
    chk({name, "_winner"}, winner, 0);
  endtask

  initial begin
    repeat (3) cyc();
    armed = 1'b1;
    check_zero("reset");
    #1 rst_n = 1'b1;
    cyc();

    // Held start button: one press, one recenter, KICKOFF then PLAY
    start_button = 1'b0;
    rec_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (recenter) chk("kick_entry", game_state, 1);
    end
    start_button = 1'b1;
    chk("rec_once", rec_cnt, 1);
    wait_state(2, 20, "play_reached");
    chk("rec_still_once", rec_cnt, 1);

    // 40 cycles of PLAY: one move tick every 4 cycles
    mv_cnt = 0;
    repeat (40) cyc();
    chk("mv40", mv_cnt, 10);

    // Single goal for team 2
    mv_cnt = 0;
    rec_cnt = 0;
    goal_team2 = 1'b1;
    cyc();
    goal_team2 = 1'b0;
    chk("goal_state", game_state, 3);
    chk("goal_s2", team2_score, 1);
    wait_state(1, 20, "goal_to_kick");
    chk("goal_no_move", mv_cnt, 0);
    chk("goal_rec", rec_cnt, 1);
    wait_state(2, 20, "goal_back_play");

    // Simultaneous goals are discarded
    goal_team1 = 1'b1;
    goal_team2 = 1'b1;
    cyc();
    goal_team1 = 1'b0;
    goal_team2 = 1'b0;
    chk("simul_state", game_state, 2);
    chk("simul_s1", team1_score, 0);
    chk("simul_s2", team2_score, 1);

    // Win for team 1 and restart
    do_reset();
    start_game();
    for (int i = 0; i < 3; i++) begin
      goal_team1 = 1'b1;
      cyc();
      goal_team1 = 1'b0;
      if (i < 2) begin
        wait_state(1, 20, "win_kick");
        wait_state(2, 20, "win_play");
      end
    end
    chk("over_state", game_state, 4);
    chk("over_winner", winner, 1);
    chk("over_s1", team1_score, 3);
    chk("over_s2", team2_score, 0);
    repeat (100) cyc();
    chk("hold_state", game_state, 4);
    chk("hold_winner", winner, 1);
    chk("hold_s1", team1_score, 3);
    chk("hold_s2", team2_score, 0);
    start_button = 1'b0;
    repeat (4) cyc();
    start_button = 1'b1;
    wait_state(1, 10, "restart_kick");
    chk("restart_s1", team1_score, 0);
    chk("restart_s2", team2_score, 0);
    chk("restart_winner", winner, 0);
    wait_state(2, 20, "restart_play");

`ifdef MATCH_PAUSE_EN
    // Pause in PLAY freezes movement and ignores goals
    pause_button = 1'b0;
    repeat (4) cyc();
    pause_button = 1'b1;
    chk("pause_state", game_state, 5);
    mv_cnt = 0;
    goal_team1 = 1'b1;
    cyc();
    goal_team1 = 1'b0;
    repeat (12) cyc();
    chk("pause_no_move", mv_cnt, 0);
    chk("pause_s1", team1_score, 0);
    pause_button = 1'b0;
    repeat (4) cyc();
    pause_button = 1'b1;
    chk("resume_state", game_state, 2);
`endif

    // Randomized goals and button activity against the model
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 19);
      goal_team1 = (r == 0) || (r == 2);
      goal_team2 = (r == 1) || (r == 2);
      if ($urandom_range(0, 24) == 0) start_button = ~start_button;
`ifdef MATCH_PAUSE_EN
      if ($urandom_range(0, 39) == 0) pause_button = ~pause_button;
`endif
      cyc();
    end
    goal_team1 = 1'b0;
    goal_team2 = 1'b0;
    start_button = 1'b1;
    pause_button = 1'b1;
    repeat (4) cyc();

    // Reset in the middle of a match
    do_reset();
    start_game();
    goal_team2 = 1'b1;
    cyc();
    goal_team2 = 1'b0;
    chk("mid_s2", team2_score, 1);
    #1 rst_n = 1'b0;
    cyc();
    check_zero("midreset");
    #1 rst_n = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/match_sequencer.md
# match_sequencer

Game-flow controller that sequences the vertical player-position controllers and the scoreboard for the quidditch match. It divides the pixel clock into a frame-rate movement tick, runs the match state machine (idle, kickoff countdown, play, goal freeze, game over), counts goals per team and issues a one-cycle recenter pulse so both players return to the start row (240). Player controllers advance position only on `move_tick`; the display reads the scores, state and winner.

## Interface
- `TICK_DIV`, 833333: clk cycles per frame tick (60 Hz at 50 MHz); must be at least 2.
- `KICKOFF_TICKS`, 120: frame ticks spent in KICKOFF; must be at least 1.
- `GOAL_HOLD_TICKS`, 90: frame ticks of freeze after a goal; must be at least 1.
- `WIN_SCORE`, 7: goals needed to win; range 1..15.

- `clk` in 1: system clock; all logic uses the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_button` in 1: active-low, asynchronous to `clk`.
- `goal_team1` in 1: one-cycle pulse; team 1 scored.
- `goal_team2` in 1: one-cycle pulse; team 2 scored.
- `move_tick` out 1: one-cycle movement enable to the player controllers.
- `recenter` out 1: one-cycle pulse; players reload position 240.
- `team1_score` out 4: team 1 goal count.
- `team2_score` out 4: team 2 goal count.
- `game_state` out 3: IDLE=0, KICKOFF=1, PLAY=2, GOAL=3, GAME_OVER=4, PAUSE=5.
- `winner` out 2: 0 = none, 1 = team 1, 2 = team 2.

## Operation
- Reset values:
  - state IDLE, and every output 0.
  - Divider and phase counters 0.
  - Button synchronizer flops 1 (released).
- Divider: free-running 0..TICK_DIV-1 in all states. `frame_tick` is the internal condition `div_cnt == TICK_DIV-1`.
- Button press detection:
  - Two-flop synchronizer, then a third flop for the edge.
  - A press is a 1→0 transition at the synchronizer output. One press yields one event however long the button is held.
- IDLE: a start press moves to KICKOFF, clears the scores and `winner`, and pulses `recenter`.
- KICKOFF:
  - The phase counter counts frame ticks.
  - On the frame tick that brings it to KICKOFF_TICKS, move to PLAY and clear the counter.
- PLAY:
  - `move_tick` is registered from `frame_tick` while in PLAY.
  - A lone goal pulse increments that team's score and enters GOAL.
  - If the new score equals WIN_SCORE, enter GAME_OVER instead and set `winner`.
  - Goal pulses on both inputs in the same cycle are discarded: no score change, state stays PLAY.
- GOAL:
  - `move_tick` is held 0 and goal inputs are ignored.
  - After GOAL_HOLD_TICKS frame ticks, pulse `recenter` and move to KICKOFF.
- GAME_OVER:
  - Scores and `winner` hold.
  - A start press behaves exactly as in IDLE.
- Start presses in KICKOFF, PLAY, GOAL and PAUSE are ignored.
- Scores are 4-bit unsigned and never wrap, because play stops at WIN_SCORE.
- Reset mid-match: everything returns to reset values immediately; any pulse in flight is dropped.

## Timing
- Start button: first sampled low at edge k → state changes at edge k+2. `recenter` is high from edge k+2 to edge k+3.
- `move_tick` is high for the one cycle following the edge where `div_cnt` wraps to 0. It is never high outside PLAY.
- Goal pulse sampled at edge k → the score updates and the state changes at edge k. The score output is registered and visible in the following cycle.
- KICKOFF→PLAY and GOAL→KICKOFF take place at the wrap edge of the qualifying frame tick. A frame tick occurring on the entry edge itself does not count.
- `recenter` is always exactly one cycle wide.

## Configuration
- `MATCH_PAUSE_EN` defined:
  - Adds input `pause_button` (1 bit, active-low), synchronized and edge-detected exactly like `start_button`.
  - A press in PLAY enters PAUSE. In PAUSE, `move_tick` is 0, goal inputs are ignored and the divider keeps running.
  - A press in PAUSE returns to PLAY. Presses in any other state are ignored.
- `MATCH_PAUSE_EN` undefined: no `pause_button` port; code 5 is never produced.

## Test plan
All scenarios use TICK_DIV=4, KICKOFF_TICKS=2, GOAL_HOLD_TICKS=3, WIN_SCORE=3.
- Reset then start: `rst_n` low, release, hold `start_button` low for 10 cycles → one `recenter` pulse and `game_state`=1. PLAY (2) is reached after 2 frame ticks; while held, the button produces no further press.
- Move ticks: in PLAY for 40 cycles → exactly 10 single-cycle `move_tick` pulses spaced 4 cycles apart, and none in KICKOFF.
- Single goal: one `goal_team2` pulse in PLAY → `team2_score`=1, `game_state`=3 and no `move_tick` for 3 frame ticks. Then one `recenter` pulse, KICKOFF, and back to PLAY.
- Simultaneous goals: both goal inputs pulsed in the same cycle → both scores unchanged and the state stays PLAY.
- Win and restart: three `goal_team1` pulses → `game_state`=4, `winner`=1, scores 3/0 held for 100 cycles. A start press then gives scores 0/0, `winner`=0 and KICKOFF.
- Pause (`MATCH_PAUSE_EN`) and mid-match reset:
  - `pause_button` press in PLAY → `game_state`=5, no `move_tick`, a goal pulse is ignored.
  - A second press → PLAY.
  - `rst_n` pulsed low → all outputs return to 0.
